mac_vector_checker: RTL
=======================

Name: mac_vector_checker

Overview:
- Parametrised stimulus/checker engine for the RISC-V fused multiply-add unit (T = A + B*C).
- Holds a loadable table of vectors: A, B, C, rounding mode, expected result and expected fflags.
- Issues one vector per cycle to a DUT of configurable pipeline latency and compares the DUT outputs PARM_LAT cycles later.
- Reports error count, first failing index and pass/fail. Sits in the testbed between the vector loader and the MAC; also usable as an on-chip BIST.

Parameters:
- PARM_XLEN, 32, operand/result width
- PARM_RM, 3, rounding-mode width
- PARM_DEPTH, 16, vector table entries (power of two, >=2)
- PARM_LAT, 3, DUT latency in cycles from operand issue to Result valid (>=1)
- PARM_ERRW, 8, error counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- load_we_i  in  1  write one table entry
- load_addr_i  in  $clog2(PARM_DEPTH)  entry index
- load_rm_i  in  PARM_RM  rounding mode
- load_a_i / load_b_i / load_c_i  in  PARM_XLEN each  operands
- load_exp_i  in  PARM_XLEN  expected result
- load_flags_i  in  4  expected {NV,OF,UF,NX}
- num_vec_i  in  $clog2(PARM_DEPTH)+1  vectors to run
- start_i  in  1  begin a run (level sampled)
- Rounding_mode_o  out  PARM_RM  to DUT
- A_o / B_o / C_o  out  PARM_XLEN each  to DUT
- issue_valid_o  out  1  operands valid this cycle
- Result_i  in  PARM_XLEN  DUT result
- NV_i / OF_i / UF_i / NX_i  in  1 each  DUT fflags
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle pulse at end of run
- pass_o  out  1  last run had zero errors
- err_cnt_o  out  PARM_ERRW  mismatches in last run, saturating
- first_err_idx_o  out  $clog2(PARM_DEPTH)  index of first mismatch

Behaviour:
- Reset (asynchronous, rst=1): FSM=IDLE; all outputs 0 except pass_o=0; table contents undefined (not reset).
- Table writes are accepted only in IDLE; load_we_i is ignored while busy_o=1.
- FSM states:
  - IDLE: start_i=1 goes to ISSUE. Clears err_cnt, first_err_idx, pass; latches n = min(num_vec_i, PARM_DEPTH). If n==0, goes directly to DONE.
  - ISSUE: each cycle drives entry[issue_idx] on A_o/B_o/C_o/Rounding_mode_o with issue_valid_o=1; issue_idx increments. After issuing index n-1, goes to DRAIN.
  - DRAIN: issue_valid_o=0 and operand outputs hold their last value; stays until the check pipe is empty (PARM_LAT cycles), then goes to DONE.
  - DONE: done_o=1 for one cycle; pass_o = (err_cnt==0); returns to IDLE.
- busy_o=1 in ISSUE and DRAIN. start_i is ignored while busy_o=1.
- Check pipe: PARM_LAT-stage shift register of {valid, idx}, loaded with {issue_valid_o, issue_idx}.
- At the pipe output with valid=1, compare Result_i against entry[idx].exp. On mismatch, err_cnt increments, saturating at all-ones; on the first mismatch of the run, first_err_idx is captured.
- Results and counters (err_cnt_o, first_err_idx_o, pass_o) hold after DONE until the next start.
- Total run length: n + PARM_LAT + 1 cycles from start_i sampled to done_o.
- Operand outputs register directly from the table (registered outputs, no combinational path from load ports).

Optional Feature:
- MAC_CHK_FLAGS_EN
  - Defined: the mismatch condition also includes {NV_i,OF_i,UF_i,NX_i} != entry.flags.
  - Undefined: fflags are ignored and only Result_i is compared; the flag storage is still written but unused.

Decomposition:
- Shared package mac_pkg:
  - rounding-mode constants RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100
  - fflag bit positions: NV=3, OF=2, UF=1, NX=0
  - FSM state enum {IDLE, ISSUE, DRAIN, DONE}
  - vector-entry struct type
- Natural sub-module: mac_chk_delay, the PARM_LAT-deep valid/index shift register with an empty flag.

Test Plan:
- Load entry0: A=0x3F800000, B=0x40000000, C=0x40400000, RM=000, exp=0x40E00000, flags=0; DUT model correct; num_vec=1 -> done_o at cycle 1+3+1, pass_o=1, err_cnt_o=0.
- Load 16 entries; model corrupts result bit0 at index 5 and index 9 -> err_cnt_o=2, first_err_idx_o=5, pass_o=0.
- num_vec_i=0 -> done_o the cycle after DONE entry; issue_valid_o never asserted; pass_o=1.
- num_vec_i=20 with PARM_DEPTH=16 -> exactly 16 issue_valid_o pulses; done_o after 16+3+1 cycles.
- rst asserted mid-ISSUE at vector 4 -> busy_o, issue_valid_o, err_cnt_o drop to 0 immediately; next start reruns from index 0.
- MAC_CHK_FLAGS_EN defined; entry exp flags=0001 and DUT NX=0 with correct result -> err_cnt_o=1. Without the macro -> err_cnt_o=0.

Source files
------------

// File: rtl/mac_pkg.sv
// +----------------------------------------------------------------------------+
// | mac_pkg                                                                    |
// | Shared constants and types for the fused multiply-add vector checker.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package mac_pkg;

  localparam logic [2:0] RNE = 3'b000;
  localparam logic [2:0] RTZ = 3'b001;
  localparam logic [2:0] RDN = 3'b010;
  localparam logic [2:0] RUP = 3'b011;
  localparam logic [2:0] RMM = 3'b100;

  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} mac_state_e;

  localparam int XLEN_DEF = 32;
  localparam int RM_DEF   = 3;

  // One vector-table entry at the default operand and rounding-mode widths.
  typedef struct packed {
    logic [RM_DEF-1:0]   rm;
    logic [XLEN_DEF-1:0] a;
    logic [XLEN_DEF-1:0] b;
    logic [XLEN_DEF-1:0] c;
    logic [XLEN_DEF-1:0] exp;
    logic [3:0]          flags;
  } mac_vec_t;

endpackage

`default_nettype wire

// File: rtl/mac_vector_checker_if.sv
// +----------------------------------------------------------------------------+
// | mac_vector_checker_if                                                      |
// | Operand issue / result return bus between the checker and the MAC.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface mac_vector_checker_if #(
  parameter int PARM_XLEN = 32,
  parameter int PARM_RM   = 3
) ();

  logic [PARM_RM-1:0]   Rounding_mode;
  logic [PARM_XLEN-1:0] A;
  logic [PARM_XLEN-1:0] B;
  logic [PARM_XLEN-1:0] C;
  logic                 issue_valid;
  logic [PARM_XLEN-1:0] Result;
  logic                 NV;
  logic                 OF;
  logic                 UF;
  logic                 NX;

  modport master (
    output Rounding_mode, A, B, C, issue_valid,
    input  Result, NV, OF, UF, NX
  );

  modport slave (
    input  Rounding_mode, A, B, C, issue_valid,
    output Result, NV, OF, UF, NX
  );

endinterface

`default_nettype wire

// File: rtl/mac_chk_delay.sv
// +----------------------------------------------------------------------------+
// | mac_chk_delay                                                              |
// | PARM_LAT-deep {valid, idx} shift register with an all-stages-empty flag.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mac_chk_delay #(
  parameter int PARM_LAT = 3,
  parameter int PARM_IW  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic [PARM_IW-1:0] idx_i,
  output logic               valid_o,
  output logic [PARM_IW-1:0] idx_o,
  output logic               empty_o
);

  logic [PARM_LAT-1:0]              valid_q;
  logic [PARM_LAT-1:0][PARM_IW-1:0] idx_q;

  generate
    if (PARM_LAT == 1) begin : g_one
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= '0;
          idx_q   <= '0;
        end else begin
          valid_q[0] <= valid_i;
          idx_q[0]   <= idx_i;
        end
      end
    end else begin : g_multi
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= '0;
          idx_q   <= '0;
        end else begin
          valid_q <= {valid_q[PARM_LAT-2:0], valid_i};
          idx_q   <= {idx_q[PARM_LAT-2:0], idx_i};
        end
      end
    end
  endgenerate

  assign valid_o = valid_q[PARM_LAT-1];
  assign idx_o   = idx_q[PARM_LAT-1];
  assign empty_o = ~|valid_q;

endmodule

`default_nettype wire

// File: rtl/mac_vector_checker.sv
// +----------------------------------------------------------------------------+
// | mac_vector_checker                                                         |
// | Vector-table stimulus/checker engine for a pipelined FMA (T = A + B*C).    |
// | Optional: `define MAC_CHK_FLAGS_EN to include fflags in the mismatch test. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mac_vector_checker
  import mac_pkg::*;
#(
  parameter int PARM_XLEN  = 32,
  parameter int PARM_RM    = 3,
  parameter int PARM_DEPTH = 16,
  parameter int PARM_LAT   = 3,
  parameter int PARM_ERRW  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_we_i,
  input  logic [$clog2(PARM_DEPTH)-1:0] load_addr_i,
  input  logic [PARM_RM-1:0]            load_rm_i,
  input  logic [PARM_XLEN-1:0]          load_a_i,
  input  logic [PARM_XLEN-1:0]          load_b_i,
  input  logic [PARM_XLEN-1:0]          load_c_i,
  input  logic [PARM_XLEN-1:0]          load_exp_i,
  input  logic [3:0]                    load_flags_i,
  input  logic [$clog2(PARM_DEPTH):0]   num_vec_i,
  input  logic                          start_i,
  mac_vector_checker_if.master          dut_if,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          pass_o,
  output logic [PARM_ERRW-1:0]          err_cnt_o,
  output logic [$clog2(PARM_DEPTH)-1:0] first_err_idx_o
);

  localparam int c_AW = $clog2(PARM_DEPTH);
  localparam int c_NW = c_AW + 1;
  localparam logic [c_NW-1:0] c_DEPTH_N = c_NW'(PARM_DEPTH);

  localparam logic [1:0] c_ST_IDLE  = IDLE;
  localparam logic [1:0] c_ST_ISSUE = ISSUE;
  localparam logic [1:0] c_ST_DRAIN = DRAIN;
  localparam logic [1:0] c_ST_DONE  = DONE;

`ifdef MAC_CHK_FLAGS_EN
  localparam logic c_CHK_FLAGS = 1'b1;
`else
  localparam logic c_CHK_FLAGS = 1'b0;
`endif

  typedef struct packed {
    logic [PARM_RM-1:0]   rm;
    logic [PARM_XLEN-1:0] a;
    logic [PARM_XLEN-1:0] b;
    logic [PARM_XLEN-1:0] c;
    logic [PARM_XLEN-1:0] exp;
    logic [3:0]           flags;
  } entry_t;

  entry_t tbl_q [PARM_DEPTH];

  logic [1:0]           state_q, state_d;
  logic [c_NW-1:0]      n_q, n_d, nxt_q, nxt_d;
  logic [c_AW-1:0]      out_idx_q, out_idx_d;
  logic                 vld_q, vld_d;
  logic [PARM_RM-1:0]   rm_q, rm_d;
  logic [PARM_XLEN-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [PARM_ERRW-1:0] err_q, err_d;
  logic [c_AW-1:0]      ferr_q, ferr_d;
  logic                 pass_q, pass_d;

  logic [c_NW-1:0] w_n_start;
  logic [c_AW-1:0] w_rd_addr;
  logic            w_load;
  logic            w_pipe_vld;
  logic [c_AW-1:0] w_pipe_idx;
  logic            w_pipe_empty;
  logic [3:0]      w_dut_flags;
  logic            w_mis;

  // Table contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (load_we_i && (state_q == c_ST_IDLE)) begin
      tbl_q[load_addr_i] <= '{rm: load_rm_i, a: load_a_i, b: load_b_i, c: load_c_i,
                              exp: load_exp_i, flags: load_flags_i};
    end
  end

  mac_chk_delay #(
    .PARM_LAT (PARM_LAT),
    .PARM_IW  (c_AW)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .valid_i (vld_q),
    .idx_i   (out_idx_q),
    .valid_o (w_pipe_vld),
    .idx_o   (w_pipe_idx),
    .empty_o (w_pipe_empty)
  );

  always_comb begin
    w_dut_flags          = '0;
    w_dut_flags[FLAG_NV] = dut_if.NV;
    w_dut_flags[FLAG_OF] = dut_if.OF;
    w_dut_flags[FLAG_UF] = dut_if.UF;
    w_dut_flags[FLAG_NX] = dut_if.NX;
  end

  assign w_mis = w_pipe_vld &&
                 ((dut_if.Result != tbl_q[w_pipe_idx].exp) ||
                  (c_CHK_FLAGS && (w_dut_flags != tbl_q[w_pipe_idx].flags)));

  assign w_n_start = (num_vec_i > c_DEPTH_N) ? c_DEPTH_N : num_vec_i;
  // The first entry is fetched on the same edge that samples start_i.
  assign w_rd_addr = (state_q == c_ST_IDLE) ? '0 : nxt_q[c_AW-1:0];

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    nxt_d     = nxt_q;
    out_idx_d = out_idx_q;
    vld_d     = vld_q;
    rm_d      = rm_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    err_d     = err_q;
    ferr_d    = ferr_q;
    pass_d    = pass_q;
    w_load    = 1'b0;

    if (w_mis) begin
      if (err_q != '1) err_d = err_q + PARM_ERRW'(1);
      if (err_q == '0) ferr_d = w_pipe_idx;
    end

    case (state_q)
      c_ST_IDLE: begin
        if (start_i) begin
          err_d  = '0;
          ferr_d = '0;
          pass_d = 1'b0;
          n_d    = w_n_start;
          if (w_n_start == '0) begin
            state_d = c_ST_DONE;
            pass_d  = 1'b1;
          end else begin
            state_d   = c_ST_ISSUE;
            w_load    = 1'b1;
            out_idx_d = '0;
            nxt_d     = c_NW'(1);
            vld_d     = 1'b1;
          end
        end
      end
      c_ST_ISSUE: begin
        if (nxt_q == n_q) begin
          vld_d   = 1'b0;
          state_d = c_ST_DRAIN;
        end else begin
          w_load    = 1'b1;
          out_idx_d = nxt_q[c_AW-1:0];
          nxt_d     = nxt_q + c_NW'(1);
        end
      end
      c_ST_DRAIN: begin
        if (w_pipe_empty) begin
          state_d = c_ST_DONE;
          pass_d  = (err_q == '0);
        end
      end
      c_ST_DONE: state_d = c_ST_IDLE;
      default:   state_d = c_ST_IDLE;
    endcase

    if (w_load) begin
      rm_d = tbl_q[w_rd_addr].rm;
      a_d  = tbl_q[w_rd_addr].a;
      b_d  = tbl_q[w_rd_addr].b;
      c_d  = tbl_q[w_rd_addr].c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= c_ST_IDLE;
      n_q       <= '0;
      nxt_q     <= '0;
      out_idx_q <= '0;
      vld_q     <= 1'b0;
      rm_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      err_q     <= '0;
      ferr_q    <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      nxt_q     <= nxt_d;
      out_idx_q <= out_idx_d;
      vld_q     <= vld_d;
      rm_q      <= rm_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      err_q     <= err_d;
      ferr_q    <= ferr_d;
      pass_q    <= pass_d;
    end
  end

  assign dut_if.Rounding_mode = rm_q;
  assign dut_if.A             = a_q;
  assign dut_if.B             = b_q;
  assign dut_if.C             = c_q;
  assign dut_if.issue_valid   = vld_q;

  assign busy_o          = (state_q == c_ST_ISSUE) || (state_q == c_ST_DRAIN);
  assign done_o          = (state_q == c_ST_DONE);
  assign pass_o          = pass_q;
  assign err_cnt_o       = err_q;
  assign first_err_idx_o = ferr_q;

endmodule

`default_nettype wire
